intercore_sr_client: RTL and testbench

Per-core initiator for the intercore special-register bus: turns core-side requests (send an intercore interrupt, acknowledge an incoming one, write core-1 disable, snapshot pending state) into single-cycle SR-bus transactions toward `intercore_sregs`. One instance per core sits between the core's interrupt/control logic and its `cN_sr_bus_*` port. It also presents a clean, glitch-free interrupt level to the core that cannot re-fire while its own clear is in flight.

---
 rtl/intercore_pkg.sv | 19 +
 rtl/intercore_sr_client.sv | 131 +++++++++++++
 tb/tb_intercore_sr_client.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intercore_pkg.sv
// rtl/intercore_pkg.sv - shared SR-bus register map and client state encoding
package intercore_pkg;

    localparam int unsigned CORES = 2;

    localparam logic [3:0] SREG_ICINT_SET   = 4'h9;
    localparam logic [3:0] SREG_ICINT_RESET = 4'hA;
    localparam logic [3:0] SREG_ICDISABLE   = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SET,
        ST_HOLD,
        ST_READ,
        ST_GUARD
    } ic_state_e;

endpackage

// File: rtl/intercore_sr_client.sv
// rtl/intercore_sr_client.sv - per-core SR-bus initiator for intercore IRQ set/clear, disable and status
module intercore_sr_client #(
    parameter int RW      = 16,
    parameter int CORES   = intercore_pkg::CORES,
    parameter int CORE_ID = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [RW-1:0]    o_sr_bus_addr,
    output logic [RW-1:0]    o_sr_bus_data_o,
    output logic             o_sr_bus_we,
    input  logic [RW-1:0]    i_sr_bus_data_i,
    input  logic             i_core_int,
    input  logic             i_send_req,
    input  logic [CORES-1:0] i_send_mask,
    output logic             o_send_ack,
    input  logic             i_irq_ack,
    input  logic             i_hold_req,
    input  logic             i_hold_val,
    output logic             o_hold_ack,
    input  logic             i_status_req,
    output logic             o_status_valid,
    output logic [CORES-1:0] o_status,
    output logic             o_irq,
    output logic             o_busy
);
    import intercore_pkg::*;

    ic_state_e        state_q, state_d;
    logic             ack_pending_q, ack_pending_d;
    logic [RW-1:0]    addr_q, addr_d, data_q, data_d;
    logic             we_q, we_d;
    logic             send_ack_q, send_ack_d;
    logic             hold_ack_q, hold_ack_d;
    logic             status_valid_q, status_valid_d;
    logic [CORES-1:0] status_q, status_d;
    logic             irq_q, irq_d;
    logic             ack_now;
    logic             unused_data_hi;

    // An ack arriving in IDLE is served this edge rather than waiting a cycle in the flag.
    assign ack_now        = ack_pending_q | i_irq_ack;
    assign unused_data_hi = ^i_sr_bus_data_i[RW-1:CORES];

    always_comb begin
        state_d        = state_q;
        ack_pending_d  = ack_now;
        addr_d         = '0;
        data_d         = '0;
        we_d           = 1'b0;
        send_ack_d     = 1'b0;
        hold_ack_d     = 1'b0;
        status_valid_d = 1'b0;
        status_d       = status_q;
        // Keep the level low while our clear is pending or still propagating through the responder.
        irq_d = i_core_int & ~ack_now & ~((state_q == ST_CLR) || (state_q == ST_GUARD));

        case (state_q)
            ST_IDLE: begin
                if (ack_now) begin
                    state_d       = ST_CLR;
                    ack_pending_d = 1'b0;
                    addr_d        = RW'(SREG_ICINT_RESET);
                    data_d        = RW'(1) << CORE_ID;
                    we_d          = 1'b1;
                end else if (i_send_req) begin
                    state_d             = ST_SET;
                    addr_d              = RW'(SREG_ICINT_SET);
                    data_d[CORES-1:0]   = i_send_mask;
                    we_d                = 1'b1;
                    send_ack_d          = 1'b1;
                end else if (i_hold_req) begin
                    state_d    = ST_HOLD;
                    hold_ack_d = 1'b1;
                    if (CORE_ID == 0) begin
                        addr_d    = RW'(SREG_ICDISABLE);
                        data_d[1] = i_hold_val;
                        we_d      = 1'b1;
                    end
                end else if (i_status_req) begin
                    state_d = ST_READ;
                    addr_d  = RW'(SREG_ICINT_SET);
                end
            end
            ST_CLR:  state_d = ST_GUARD;
            ST_READ: begin
                state_d        = ST_IDLE;
                status_d       = i_sr_bus_data_i[CORES-1:0];
                status_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            ack_pending_q  <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            we_q           <= 1'b0;
            send_ack_q     <= 1'b0;
            hold_ack_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_q       <= '0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_pending_q  <= ack_pending_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            we_q           <= we_d;
            send_ack_q     <= send_ack_d;
            hold_ack_q     <= hold_ack_d;
            status_valid_q <= status_valid_d;
            status_q       <= status_d;
            irq_q          <= irq_d;
        end
    end

    assign o_sr_bus_addr   = addr_q;
    assign o_sr_bus_data_o = data_q;
    assign o_sr_bus_we     = we_q;
    assign o_send_ack      = send_ack_q;
    assign o_hold_ack      = hold_ack_q;
    assign o_status_valid  = status_valid_q;
    assign o_status        = status_q;
    assign o_irq           = irq_q;
    assign o_busy          = (state_q != ST_IDLE) | ack_pending_q;

endmodule

// File: tb/tb_intercore_sr_client.sv
// tb/tb_intercore_sr_client.sv - two-core bench with responder model and transaction-queue reference
module tb_intercore_sr_client;

    localparam logic [1:0] K_IDLE = 2'd0, K_BUS = 2'd1, K_MASK = 2'd2, K_READ = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic        we;
        logic        sack;
        logic        hack;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_o [2];
    logic [15:0] data_o [2];
    logic        we_o [2], sack_o [2], hack_o [2], sval_o [2], irq_o [2], busy_o [2];
    logic [1:0]  status_o [2];
    logic [1:0]  send_req, irq_ack, hold_req, hold_val, status_req, int_force;
    logic [1:0]  send_mask [2];
    logic [1:0]  irq_state, sr_nx, core_int;
    logic        c1_dis;
    logic [15:0] bus_din;

    ent_t        mq [2][4];
    int          mlen [2];
    ent_t        mcur [2];
    logic        mackp [2], e_irq [2], e_sval [2], e_busy [2];
    logic [1:0]  e_status [2];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [39:0] obs, expv;

    always #5 clk = ~clk;

    assign core_int = irq_state | int_force;
    assign bus_din  = {14'b0, irq_state};

    intercore_sr_client #(.RW(16), .CORES(2), .CORE_ID(0)) u_c0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_sr_bus_addr(addr_o[0]), .o_sr_bus_data_o(data_o[0]), .o_sr_bus_we(we_o[0]),
        .i_sr_bus_data_i(bus_din), .i_core_int(core_int[0]),
        .i_send_req(send_req[0]), .i_send_mask(send_mask[0]), .o_send_ack(sack_o[0]),
        .i_irq_ack(irq_ack[0]), .i_hold_req(hold_req[0]), .i_hold_val(hold_val[0]),
        .o_hold_ack(hack_o[0]), .i_status_req(status_req[0]), .o_status_valid(sval_o[0]),
        .o_status(status_o[0]), .o_irq(irq_o[0]), .o_busy(busy_o[0])
    );

    intercore_sr_client #(.RW(16), .CORES(2), .CORE_ID(1)) u_c1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_sr_bus_addr(addr_o[1]), .o_sr_bus_data_o(data_o[1]), .o_sr_bus_we(we_o[1]),
        .i_sr_bus_data_i(bus_din), .i_core_int(core_int[1]),
        .i_send_req(send_req[1]), .i_send_mask(send_mask[1]), .o_send_ack(sack_o[1]),
        .i_irq_ack(irq_ack[1]), .i_hold_req(hold_req[1]), .i_hold_val(hold_val[1]),
        .o_hold_ack(hack_o[1]), .i_status_req(status_req[1]), .o_status_valid(sval_o[1]),
        .o_status(status_o[1]), .o_irq(irq_o[1]), .o_busy(busy_o[1])
    );

    // Responder: all clears of an edge apply before all sets.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_state <= 2'b00;
            c1_dis    <= 1'b1;
        end else begin
            sr_nx = irq_state;
            for (int c = 0; c < 2; c++)
                if (we_o[c] && addr_o[c] == 16'hA) sr_nx = sr_nx & ~data_o[c][1:0];
            for (int c = 0; c < 2; c++) begin
                if (we_o[c] && addr_o[c] == 16'h9) sr_nx = sr_nx | data_o[c][1:0];
                if (we_o[c] && addr_o[c] == 16'hB) c1_dis <= data_o[c][1];
            end
            irq_state <= sr_nx;
        end
    end

    task automatic push(input int c, input ent_t e);
        mq[c][mlen[c]] = e;
        mlen[c] = mlen[c] + 1;
    endtask

    // Reference: each accepted request becomes a list of expected bus cycles ending in one idle cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                mlen[c] = 0; mcur[c] = '0; mackp[c] = 1'b0;
                e_irq[c] = 1'b0; e_sval[c] = 1'b0; e_status[c] = 2'b00; e_busy[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic ackn;
                ackn     = mackp[c] | irq_ack[c];
                e_irq[c] = core_int[c] & ~ackn & (mcur[c].kind != K_MASK);
                e_sval[c] = (mcur[c].kind == K_READ);
                if (mcur[c].kind == K_READ) e_status[c] = irq_state;
                if (mlen[c] == 0) begin
                    if (ackn) begin
                        push(c, '{kind: K_MASK, addr: 16'hA, data: 16'(1 << c), we: 1'b1, sack: 1'b0, hack: 1'b0});
                        push(c, '{kind: K_MASK, default: '0});
                        push(c, '0);
                        ackn = 1'b0;
                    end else if (send_req[c]) begin
                        push(c, '{kind: K_BUS, addr: 16'h9, data: {14'b0, send_mask[c]}, we: 1'b1, sack: 1'b1, hack: 1'b0});
                        push(c, '0);
                    end else if (hold_req[c]) begin
                        if (c == 0)
                            push(c, '{kind: K_BUS, addr: 16'hB, data: {14'b0, hold_val[c], 1'b0}, we: 1'b1, sack: 1'b0, hack: 1'b1});
                        else
                            push(c, '{kind: K_BUS, addr: 16'h0, data: 16'h0, we: 1'b0, sack: 1'b0, hack: 1'b1});
                        push(c, '0);
                    end else if (status_req[c]) begin
                        push(c, '{kind: K_READ, addr: 16'h9, default: '0});
                        push(c, '0);
                    end
                end
                mackp[c] = ackn;
                if (mlen[c] > 0) begin
                    mcur[c] = mq[c][0];
                    for (int i = 0; i < 3; i++) mq[c][i] = mq[c][i+1];
                    mlen[c] = mlen[c] - 1;
                end else begin
                    mcur[c] = '0;
                end
                e_busy[c] = (mcur[c].kind != K_IDLE) | mackp[c];
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; int_force = 2'b11;
        send_req = '0; irq_ack = '0; hold_req = '0; hold_val = '0; status_req = '0;
        send_mask[0] = '0; send_mask[1] = '0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            obs = {addr_o[c], data_o[c], we_o[c], sack_o[c], hack_o[c], sval_o[c], status_o[c], irq_o[c], busy_o[c]};
            n_checks++;
            if (obs !== 40'h0) begin n_errors++; $display("FAIL reset_outputs core%0d got %h want 0", c, obs); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (irq_o[c] !== 1'b1) begin n_errors++; $display("FAIL reset_irq_lag core%0d got %b want 1", c, irq_o[c]); end
        end
        int_force = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midtx();
        @(negedge clk); send_req[0] = 1'b1; send_mask[0] = 2'b01;
        @(posedge clk); #1;
        n_checks++;
        if (we_o[0] !== 1'b1) begin n_errors++; $display("FAIL midtx_we_before got %b want 1", we_o[0]); end
        rst_n = 1'b0; #1;
        n_checks++;
        if ({we_o[0], busy_o[0], addr_o[0]} !== 18'h0) begin
            n_errors++; $display("FAIL midtx_abort got %b %b %h want 0 0 0000", we_o[0], busy_o[0], addr_o[0]);
        end
        @(negedge clk); send_req[0] = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({we_o[0], irq_state} !== 3'b000) begin
            n_errors++; $display("FAIL midtx_no_write got we=%b state=%b want 0 00", we_o[0], irq_state);
        end
    endtask

    task automatic test_send();
        @(negedge clk); send_req[0] = 1'b1; send_mask[0] = 2'b10;
        @(negedge clk);
        n_checks++;
        if ({addr_o[0], data_o[0], we_o[0], sack_o[0]} !== {16'h9, 16'h2, 1'b1, 1'b1}) begin
            n_errors++; $display("FAIL send_bus got %h %h %b %b want 0009 0002 1 1", addr_o[0], data_o[0], we_o[0], sack_o[0]);
        end
        send_req[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (irq_state !== 2'b10) begin n_errors++; $display("FAIL send_responder got %b want 10", irq_state); end
        @(negedge clk);
        n_checks++;
        if (irq_o[1] !== 1'b1) begin n_errors++; $display("FAIL send_c1_irq got %b want 1", irq_o[1]); end
    endtask

    task automatic test_clear();
        @(negedge clk); irq_ack[1] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({addr_o[1], data_o[1], we_o[1], irq_o[1], busy_o[1]} !== {16'hA, 16'h2, 1'b1, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL clear_bus got %h %h %b irq=%b busy=%b want 000a 0002 1 0 1", addr_o[1], data_o[1], we_o[1], irq_o[1], busy_o[1]);
        end
        irq_ack[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({we_o[1], irq_o[1], busy_o[1]} !== 3'b001) begin
            n_errors++; $display("FAIL clear_guard got we=%b irq=%b busy=%b want 0 0 1", we_o[1], irq_o[1], busy_o[1]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({irq_o[1], busy_o[1], irq_state[1]} !== 3'b000) begin
            n_errors++; $display("FAIL clear_after got irq=%b busy=%b bit=%b want 0 0 0", irq_o[1], busy_o[1], irq_state[1]);
        end
    endtask

    task automatic test_ack_and_send();
        @(negedge clk); send_req[1] = 1'b1; send_mask[1] = 2'b01;
        @(negedge clk); send_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq_o[0] !== 1'b1) begin n_errors++; $display("FAIL ackset_pre_irq got %b want 1", irq_o[0]); end
        irq_ack[0] = 1'b1; send_req[0] = 1'b1; send_mask[0] = 2'b01;
        @(negedge clk); irq_ack[0] = 1'b0;
        n_checks++;
        if ({addr_o[0], data_o[0], we_o[0], sack_o[0]} !== {16'hA, 16'h1, 1'b1, 1'b0}) begin
            n_errors++; $display("FAIL ackset_clr got %h %h %b %b want 000a 0001 1 0", addr_o[0], data_o[0], we_o[0], sack_o[0]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({we_o[0], sack_o[0], busy_o[0]} !== 3'b000) begin
            n_errors++; $display("FAIL ackset_idle got we=%b sack=%b busy=%b want 0 0 0", we_o[0], sack_o[0], busy_o[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({addr_o[0], data_o[0], we_o[0], sack_o[0]} !== {16'h9, 16'h1, 1'b1, 1'b1}) begin
            n_errors++; $display("FAIL ackset_set got %h %h %b %b want 0009 0001 1 1", addr_o[0], data_o[0], we_o[0], sack_o[0]);
        end
        send_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq_o[0] !== 1'b1) begin n_errors++; $display("FAIL ackset_reassert got %b want 1", irq_o[0]); end
    endtask

    task automatic test_hold();
        @(negedge clk); hold_req[0] = 1'b1; hold_val[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({addr_o[0], data_o[0], we_o[0], hack_o[0]} !== {16'hB, 16'h0, 1'b1, 1'b1}) begin
            n_errors++; $display("FAIL hold_c0 got %h %h %b %b want 000b 0000 1 1", addr_o[0], data_o[0], we_o[0], hack_o[0]);
        end
        hold_req[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (c1_dis !== 1'b0) begin n_errors++; $display("FAIL hold_disable got %b want 0", c1_dis); end
        hold_req[1] = 1'b1; hold_val[1] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({addr_o[1], we_o[1], hack_o[1]} !== {16'h0, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL hold_c1 got %h %b %b want 0000 0 1", addr_o[1], we_o[1], hack_o[1]);
        end
        hold_req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_status();
        @(negedge clk); send_req[1] = 1'b1; send_mask[1] = 2'b11;
        @(negedge clk); send_req[1] = 1'b0;
        @(negedge clk); status_req[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({addr_o[0], we_o[0], sval_o[0]} !== {16'h9, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL status_read got %h %b %b want 0009 0 0", addr_o[0], we_o[0], sval_o[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({status_o[0], sval_o[0]} !== 3'b111) begin
            n_errors++; $display("FAIL status_value got %b %b want 11 1", status_o[0], sval_o[0]);
        end
        status_req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                obs  = {addr_o[c], data_o[c], we_o[c], sack_o[c], hack_o[c], sval_o[c], status_o[c], irq_o[c], busy_o[c]};
                expv = {mcur[c].addr, mcur[c].data, mcur[c].we, mcur[c].sack, mcur[c].hack,
                        e_sval[c], e_status[c], e_irq[c], e_busy[c]};
                n_checks++;
                if (obs !== expv) begin
                    n_errors++; $display("FAIL random cyc%0d core%0d got %h want %h", cyc, c, obs, expv);
                end
                if (send_req[c] && mcur[c].sack) send_req[c] = 1'b0;
                else if (!send_req[c] && $urandom_range(0, 3) == 0) begin
                    send_req[c] = 1'b1; send_mask[c] = 2'($urandom_range(0, 3));
                end
                if (hold_req[c] && mcur[c].hack) hold_req[c] = 1'b0;
                else if (!hold_req[c] && $urandom_range(0, 5) == 0) begin
                    hold_req[c] = 1'b1; hold_val[c] = 1'($urandom_range(0, 1));
                end
                if (status_req[c] && e_sval[c]) status_req[c] = 1'b0;
                else if (!status_req[c] && $urandom_range(0, 4) == 0) status_req[c] = 1'b1;
                irq_ack[c] = ($urandom_range(0, 7) == 0);
            end
        end
        send_req = '0; hold_req = '0; status_req = '0; irq_ack = '0;
        repeat (6) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if ({busy_o[c], we_o[c]} !== 2'b00) begin
                n_errors++; $display("FAIL drain core%0d got busy=%b we=%b want 0 0", c, busy_o[c], we_o[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midtx();
        test_send();
        test_clear();
        test_ack_and_send();
        test_hold();
        test_status();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
